// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module mc_main_control (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JUMP    = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    state_t cur;
    state_t nxt;

    assign state = cur;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur     <= S_RESET;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE && nxt == S_TRAP)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt           = cur;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        unique case (cur)
            S_RESET: nxt = S_FETCH;
            S_FETCH: begin
                // PC+4 and IR load only on the cycle memory delivers
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready)
                    nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDI_EX;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    nxt = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready)
                    nxt = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                nxt           = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                nxt       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                nxt       = S_FETCH;
            end
            S_TRAP: nxt = S_TRAP;
            default: nxt = S_RESET;
        endcase
    end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
Multicycle main control FSM for the MIPS datapath.
- Sequences every instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath enables, muxes, and the 2-bit alu_op consumed directly by alu_control.
- Stretches fetch and memory states with a memory ready handshake.

Parameters:
none (opcodes are fixed constants: R 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, addi 6'b001000, j 6'b000010)

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
opcode  input  6  instr[31:26] from IR, sampled in DECODE
mem_ready  input  1  memory completes current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
iord  output  1  memory address mux: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  RF write data: 0=ALUOut, 1=MDR
reg_dst  output  1  RF write addr: 0=rt, 1=rd
reg_write  output  1  RF write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00 add, 01 sub, 10 funct, 11 addi; to alu_control
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state encoding (debug)
illegal  output  1  sticky illegal-opcode flag

Behaviour:
- State encoding: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, ADDI_EX=10, ADDI_WB=11, JUMP=12, TRAP=13. Codes 14 and 15 go to RESET.
- rstn=0: state=RESET immediately, asynchronously; illegal=0. All outputs not listed for a state are 0.
- RESET: all outputs 0. Next state FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - pc_write and ir_write equal mem_ready (gated), so PC increments exactly once per fetch.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEMADR
  - R → EXEC
  - beq → BRANCH
  - addi → ADDI_EX
  - j → JUMP
  - any other opcode → TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD if lw, MEMWR if sw.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=11. Next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- TRAP: all outputs 0 except illegal=1. Stays in TRAP until rstn=0.
- illegal:
  - Registered; set on the DECODE→TRAP transition, so it reads 1 in the first TRAP cycle.
  - Cleared only by reset.
- opcode is used only in DECODE and MEMADR; IR holds it stable through the instruction.
- Reset asserted mid-instruction aborts it. No write enables are asserted from the reset edge onward.
- Cycle counts with mem_ready=1: R 4, lw 5, sw 4, beq 3, addi 4, j 3. Each memory wait cycle adds 1.

Test Plan:
1. Reset, then R opcode, mem_ready=1 → state sequence 0,1,2,7,8,1; alu_op=10 in EXEC; reg_write=1 and reg_dst=1 only in RWB; pc_write=1 only in FETCH.
2. lw with mem_ready low for 2 cycles in FETCH and 3 in MEMRD → FETCH lasts 3 cycles with pc_write and ir_write high only in the last; MEMRD lasts 4 cycles with iord=1; MEMWB has mem_to_reg=1; total 10 cycles.
3. sw, then beq, then j back-to-back → sw: MEMWR has mem_write=1 and reg_write never 1. beq: BRANCH has alu_op=01, pc_write_cond=1, pc_source=01. j: JUMP has pc_write=1, pc_source=10.
4. addi opcode 6'b001000 → ADDI_EX alu_src_b=10, alu_op=11; ADDI_WB reg_write=1, reg_dst=0; 4 cycles total.
5. opcode 6'b111111 in DECODE → state 13, illegal=1 next cycle, all write enables 0 indefinitely; rstn pulse → state 0, illegal=0.
6. Drop rstn asynchronously mid-MEMWR with mem_ready=0 → state=0 and mem_write=0 before the next clock edge; after release, FETCH follows RESET.
